edge_rasterizer: RTL and testbench
==================================

EDGE_RASTERIZER -- requirements
Module: edge_rasterizer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, single clock; all state changes on its rising edge
- Reset, in, 1, asynchronous, active-high reset
- draw_start, in, 1, one-cycle pulse that starts rendering the FIFO contents
- triangle_data, in, [2:0][1:0][9:0], FIFO head: vertex v, [0]=x, [1]=y, unsigned
- fifo_empty, in, 1, FIFO holds no triangles
- fifo_r, out, 1, one-cycle FIFO pop pulse
- DrawX, out, 10, pixel x
- DrawY, out, 10, pixel y
- pixel_valid, out, 1, DrawX/DrawY form a write to the frame buffer this cycle
- draw_done, out, 1, one-cycle pulse when the FIFO has drained and the last edge is finished

Function
REQ-003 States: IDLE, FETCH, LATCH, EDGE_INIT, EDGE_RUN, NEXT_EDGE, DONE.
REQ-004 IDLE + draw_start: go to DONE if fifo_empty=1, otherwise go to FETCH. draw_start in any other state is ignored.
REQ-005 FETCH: assert fifo_r for exactly one cycle, then go to LATCH.
REQ-006 LATCH: register all six coordinates from triangle_data. Data is valid one cycle after the fifo_r pulse. Clear the edge index to 0 and go to EDGE_INIT.
REQ-007 Edge order: 0 = v0->v1, 1 = v1->v2, 2 = v2->v0. Shared vertices are emitted twice; this is allowed.
REQ-008 EDGE_INIT (one cycle) computes:
- dx=|x1-x0| and dy=|y1-y0|, 10-bit unsigned
- sx=+1 if x1>x0, else -1; sy likewise
- err=dx-dy, 12-bit signed
- current point = start endpoint
REQ-009 EDGE_RUN emits one pixel per cycle: pixel_valid=1 with DrawX/DrawY = current point, subject to REQ-012.
REQ-010 Midpoint step after each emitted pixel, with e2=2*err (12-bit signed):
- if e2 > -dy: err-=dy, x+=sx
- if e2 < dx: err+=dx, y+=sy
- both updates apply in the same cycle when both conditions hold
- the edge ends after the cycle that emits the end endpoint; total pixels per edge = max(dx,dy)+1
REQ-011 Degenerate edge (identical endpoints) emits exactly one pixel.
REQ-012 Clipping: pixel_valid=0 whenever current x>=SCREEN_W or y>=SCREEN_H. The step counter still advances.
REQ-013 NEXT_EDGE: if edge index<2, increment it and go to EDGE_INIT. Otherwise go to FETCH if fifo_empty=0, or to DONE if fifo_empty=1.
REQ-014 DONE: assert draw_done for one cycle, then go to IDLE. Latency from draw_start (FIFO empty) to draw_done is 1 cycle.
REQ-015 pixel_valid=0 and fifo_r=0 in every state except where stated above.
REQ-016 DrawX/DrawY and pixel_valid are registered outputs. Each edge costs 1 init cycle plus its pixel cycles; each triangle costs 2 fetch cycles plus 3 edge-advance cycles.
REQ-017 Arithmetic: coordinate updates stay within 0..1023 by construction. There is no wrap, because steps stop at the endpoint.

Reset
REQ-018 Reset asserted drives the following immediately, regardless of state (including mid-edge):
- state=IDLE
- fifo_r=0, pixel_valid=0, draw_done=0
- DrawX=0, DrawY=0
- all internal registers=0
REQ-019 Operation after reset release requires a new draw_start. No pop occurs during or because of reset.

Structure
REQ-020 A shared package holds:
- the vertex/triangle packed typedef ([2:0][1:0][9:0])
- coordinate width 10
- SCREEN_W/SCREEN_H defaults
- the state enum
REQ-021 The per-edge midpoint stepper (REQ-008..REQ-011) is one sub-module, midpoint_line:
- inputs: endpoints, init, step
- outputs: x, y, last
edge_rasterizer holds the FSM, the triangle latch, the edge selection and clipping.

Verification
REQ-022 draw_start with fifo_empty=1 -> no fifo_r; draw_done=1 exactly one cycle later; no pixel_valid.
REQ-023 Triangle (10,10),(13,10),(10,13) -> 12 valid pixels: (10..13,10); (13,10),(12,11),(11,12),(10,13); (10,13..10). Then draw_done.
REQ-024 Single edge (0,0)->(2,5) (steep) -> 6 pixels, y=0..5, each y once, x monotonic non-decreasing, ending at (2,5).
REQ-025 Vertex (700,10) with others on-screen -> no pixel_valid with x>=640; remaining pixels match the unclipped sequence; cycle count unchanged.
REQ-026 Two triangles queued -> exactly two fifo_r pulses, second only after the 3rd edge of the first; one draw_done after the second.
REQ-027 Reset asserted mid EDGE_RUN -> outputs zero in the same cycle; after release, IDLE with no fifo_r until draw_start.

Source files
------------

// File: rtl/edge_rasterizer_pkg.sv
// Shared types and constants for the triangle edge rasterizer.
// The triangle layout is [vertex][0=x,1=y][coordinate bits].
package edge_rasterizer_pkg;
  localparam int COORD_W      = 10;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic [COORD_W-1:0]             coord_t;
  typedef logic [1:0][COORD_W-1:0]        vertex_t;
  typedef logic [2:0][1:0][COORD_W-1:0]   triangle_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    EDGE_INIT = 3'd3,
    EDGE_RUN  = 3'd4,
    NEXT_EDGE = 3'd5,
    DONE      = 3'd6
  } state_t;
endpackage

// File: rtl/edge_rasterizer_midpoint_line.sv
// Integer midpoint (Bresenham) stepper for one edge: init loads the endpoints,
// each step advances one pixel, last flags that the current point is the end.
module midpoint_line
  import edge_rasterizer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic               i_init,
  input  logic               i_step,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last
);
  logic [COORD_W-1:0] r_x, r_y, r_x1, r_y1, r_dx, r_dy;
  logic               r_sx_neg, r_sy_neg;
  logic signed [11:0] r_err;

  logic [COORD_W-1:0] w_dx, w_dy;
  logic signed [11:0] w_dx_s, w_dy_s, w_e2, w_err_next;
  logic               w_step_x, w_step_y;

  always_comb begin
    w_dx       = (i_x1 > i_x0) ? i_x1 - i_x0 : i_x0 - i_x1;
    w_dy       = (i_y1 > i_y0) ? i_y1 - i_y0 : i_y0 - i_y1;
    w_dx_s     = $signed({2'b00, r_dx});
    w_dy_s     = $signed({2'b00, r_dy});
    w_e2       = r_err <<< 1;
    // Both decisions use the pre-step error term, so a diagonal move updates err twice.
    w_step_x   = (w_e2 > -w_dy_s);
    w_step_y   = (w_e2 < w_dx_s);
    w_err_next = r_err - (w_step_x ? w_dy_s : 12'sd0) + (w_step_y ? w_dx_s : 12'sd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
    end else if (i_init) begin
      r_x      <= i_x0;
      r_y      <= i_y0;
      r_x1     <= i_x1;
      r_y1     <= i_y1;
      r_dx     <= w_dx;
      r_dy     <= w_dy;
      r_sx_neg <= !(i_x1 > i_x0);
      r_sy_neg <= !(i_y1 > i_y0);
      r_err    <= $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
    end else if (i_step) begin
      r_err <= w_err_next;
      if (w_step_x) r_x <= r_sx_neg ? r_x - 10'd1 : r_x + 10'd1;
      if (w_step_y) r_y <= r_sy_neg ? r_y - 10'd1 : r_y + 10'd1;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_x1) && (r_y == r_y1);
endmodule

// File: rtl/edge_rasterizer.sv
// Draws the three edges of every triangle queued in an external FIFO, one
// pixel per cycle, clipping pixels outside the visible screen.
module edge_rasterizer
  import edge_rasterizer_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
)(
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        draw_start,
  input  logic [2:0][1:0][COORD_W-1:0] triangle_data,
  input  logic                        fifo_empty,
  output logic                        fifo_r,
  output logic [COORD_W-1:0]          DrawX,
  output logic [COORD_W-1:0]          DrawY,
  output logic                        pixel_valid,
  output logic                        draw_done,
  output logic [2:0]                  o_dbg_state
);
  localparam logic [COORD_W:0] LIM_W = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] LIM_H = (COORD_W+1)'(SCREEN_H);

  state_t             r_state, w_next_state;
  triangle_t          r_tri;
  logic [1:0]         r_edge_idx;
  vertex_t            w_start_v, w_end_v;
  logic [COORD_W-1:0] w_x, w_y;
  logic               w_last, w_init, w_step, w_on_screen;

  // FIFO pop: fifo_r pulses for one cycle in FETCH and the popped triangle is
  // expected on triangle_data during the following LATCH cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (draw_start) begin
          if (fifo_empty) w_next_state = DONE;
          else            w_next_state = FETCH;
        end
      end
      FETCH:     w_next_state = LATCH;
      LATCH:     w_next_state = EDGE_INIT;
      EDGE_INIT: w_next_state = EDGE_RUN;
      EDGE_RUN:  if (w_last) w_next_state = NEXT_EDGE;
      NEXT_EDGE: begin
        if (r_edge_idx < 2'd2) w_next_state = EDGE_INIT;
        else if (fifo_empty)   w_next_state = DONE;
        else                   w_next_state = FETCH;
      end
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    fifo_r      = (r_state == FETCH);
    draw_done   = (r_state == DONE);
    pixel_valid = (r_state == EDGE_RUN) && w_on_screen;
    DrawX       = w_x;
    DrawY       = w_y;
    w_init      = (r_state == EDGE_INIT);
    w_step      = (r_state == EDGE_RUN) && !w_last;
    o_dbg_state = r_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tri      <= '0;
      r_edge_idx <= '0;
    end else if (r_state == LATCH) begin
      r_tri      <= triangle_data;
      r_edge_idx <= '0;
    end else if (r_state == NEXT_EDGE && r_edge_idx < 2'd2) begin
      r_edge_idx <= r_edge_idx + 2'd1;
    end
  end

  // Edge 2 closes the triangle back to vertex 0.
  always_comb begin
    w_start_v = r_tri[0];
    w_end_v   = r_tri[1];
    case (r_edge_idx)
      2'd1: begin w_start_v = r_tri[1]; w_end_v = r_tri[2]; end
      2'd2: begin w_start_v = r_tri[2]; w_end_v = r_tri[0]; end
      default: ;
    endcase
  end

  assign w_on_screen = ({1'b0, w_x} < LIM_W) && ({1'b0, w_y} < LIM_H);

  midpoint_line u_line (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_x0   (w_start_v[0]),
    .i_y0   (w_start_v[1]),
    .i_x1   (w_end_v[0]),
    .i_y1   (w_end_v[1]),
    .i_init (w_init),
    .i_step (w_step),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );
endmodule

// File: tb/tb_edge_rasterizer.sv
// Bench for edge_rasterizer: a FIFO model feeds triangles, a monitor captures
// pixels, and an integer line-drawing model supplies expected pixels and timing.
module tb_edge_rasterizer;
  import edge_rasterizer_pkg::*;

  localparam int SW = 640;
  localparam int SH = 480;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       draw_start = 1'b0;
  triangle_t  triangle_data = '0;
  logic       fifo_empty = 1'b1;
  logic       fifo_r, pixel_valid, draw_done;
  logic [9:0] DrawX, DrawY;
  logic [2:0] dbg_state;

  triangle_t   fifo_q[$];
  triangle_t   batch[$];
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  int          pop_px[$];
  int          pop_cnt, done_cnt;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    triangle_t t;
    int        exp_valid;
    int        exp_lat;
  } vec_t;
  vec_t vecs[5];

  edge_rasterizer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .draw_start    (draw_start),
    .triangle_data (triangle_data),
    .fifo_empty    (fifo_empty),
    .fifo_r        (fifo_r),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .pixel_valid   (pixel_valid),
    .draw_done     (draw_done),
    .o_dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // FIFO model and output monitor, both sampling mid-cycle
  always @(negedge Clk) begin
    if (fifo_r) begin
      pop_cnt++;
      pop_px.push_back(got_q.size());
      if (fifo_q.size() > 0) triangle_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
    if (pixel_valid) got_q.push_back({DrawX, DrawY});
    if (draw_done) done_cnt++;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic triangle_t mk(int x0, int y0, int x1, int y1, int x2, int y2);
    triangle_t t;
    t[0][0] = 10'(x0); t[0][1] = 10'(y0);
    t[1][0] = 10'(x1); t[1][1] = 10'(y1);
    t[2][0] = 10'(x2); t[2][1] = 10'(y2);
    return t;
  endfunction

  // Reference line: walk from start to end with the integer midpoint rule,
  // queue on-screen pixels, return the number of pixel cycles spent.
  function automatic int model_edge(int x0, int y0, int x1, int y1);
    int dx, dy, sx, sy, err, e2, x, y, n;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x1 > x0) ? 1 : -1;
    sy = (y1 > y0) ? 1 : -1;
    err = dx - dy;
    x = x0; y = y0; n = 0;
    forever begin
      n++;
      if (x < SW && y < SH) exp_q.push_back({10'(x), 10'(y)});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
    return n;
  endfunction

  task automatic run_batch(input string name);
    int lat, exp_lat, n_first, mism, n;
    exp_q.delete(); got_q.delete(); pop_px.delete();
    pop_cnt = 0; done_cnt = 0;
    exp_lat = 1; n_first = 0;
    foreach (batch[i]) begin
      exp_lat += 2;
      for (int e = 0; e < 3; e++)
        exp_lat += 2 + model_edge(batch[i][e][0], batch[i][e][1],
                                  batch[i][(e+1)%3][0], batch[i][(e+1)%3][1]);
      if (i == 0) n_first = exp_q.size();
      fifo_q.push_back(batch[i]);
    end
    @(negedge Clk); draw_start = 1'b1;
    @(negedge Clk); draw_start = 1'b0; lat = 1;
    while (!draw_done && lat < exp_lat + 64) begin
      @(negedge Clk); lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    @(negedge Clk);
    check({name, " done one cycle"}, int'(draw_done), 0);
    check({name, " done count"}, done_cnt, 1);
    check({name, " pops"}, pop_cnt, batch.size());
    if (batch.size() >= 2 && pop_px.size() >= 2)
      check({name, " second pop after first triangle"}, pop_px[1], n_first);
    check({name, " pixel count"}, got_q.size(), exp_q.size());
    mism = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
    check({name, " pixel mismatches"}, mism, 0);
  endtask

  initial begin
    int bx, by, nt, n_valid, mono;
    int e23_x[12];
    int e23_y[12];

    // Hand-derived vectors: {triangle, valid pixels, draw_start->draw_done cycles}
    vecs[0] = '{mk(10, 10, 13, 10, 10, 13), 12, 21};
    vecs[1] = '{mk(5, 5, 5, 5, 5, 5), 3, 12};
    vecs[2] = '{mk(0, 0, 2, 5, 0, 0), 13, 22};
    vecs[3] = '{mk(700, 10, 600, 10, 600, 20), 91, 222};
    vecs[4] = '{mk(0, 479, 0, 481, 1, 481), 2, 17};
    e23_x = '{10, 11, 12, 13, 13, 12, 11, 10, 10, 10, 10, 10};
    e23_y = '{10, 10, 10, 10, 10, 11, 12, 13, 13, 12, 11, 10};

    // Reset state
    #12;
    check("reset pixel_valid", int'(pixel_valid), 0);
    check("reset fifo_r", int'(fifo_r), 0);
    check("reset draw_done", int'(draw_done), 0);
    check("reset DrawX", int'(DrawX), 0);
    check("reset DrawY", int'(DrawY), 0);
    check("reset state", int'(dbg_state), int'(IDLE));
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Empty FIFO: immediate draw_done, no pop, no pixels
    batch.delete();
    run_batch("empty");

    // Table of single triangles
    for (int v = 0; v < 5; v++) begin
      batch.delete(); batch.push_back(vecs[v].t);
      run_batch($sformatf("vec%0d", v));
      check($sformatf("vec%0d valid table", v), got_q.size(), vecs[v].exp_valid);
      if (v == 0) begin
        n_valid = 0;
        for (int i = 0; i < 12 && i < got_q.size(); i++)
          if (got_q[i] === {10'(e23_x[i]), 10'(e23_y[i])}) n_valid++;
        check("tri23 hand sequence", n_valid, 12);
      end
      if (v == 2) begin
        mono = 0;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
          if (int'(got_q[i][9:0]) != i) mono++;
          if (i > 0 && got_q[i][19:10] < got_q[i-1][19:10]) mono++;
        end
        check("steep edge y order and x monotonic", mono, 0);
        check("steep edge end point", (got_q.size() > 5) ? int'(got_q[5]) : -1,
              int'({10'd2, 10'd5}));
      end
    end

    // Two queued triangles
    batch.delete();
    batch.push_back(mk(10, 10, 13, 10, 10, 13));
    batch.push_back(mk(100, 100, 90, 120, 130, 105));
    run_batch("two triangles");

    // Randomized batches with off-screen coordinates mixed in
    for (int b = 0; b < 8; b++) begin
      batch.delete();
      nt = $urandom_range(1, 3);
      for (int t = 0; t < nt; t++) begin
        bx = $urandom_range(0, 900);
        by = $urandom_range(0, 900);
        batch.push_back(mk(bx + $urandom_range(0, 120), by + $urandom_range(0, 120),
                           bx + $urandom_range(0, 120), by + $urandom_range(0, 120),
                           bx + $urandom_range(0, 120), by + $urandom_range(0, 120)));
      end
      run_batch($sformatf("rand%0d", b));
    end

    // Reset in the middle of a long edge
    batch.delete(); batch.push_back(mk(0, 0, 300, 0, 0, 0));
    fifo_q.push_back(batch[0]);
    @(negedge Clk); draw_start = 1'b1;
    @(negedge Clk); draw_start = 1'b0;
    repeat (20) @(negedge Clk);
    check("mid-edge pixel_valid before reset", int'(pixel_valid), 1);
    #2 Reset = 1'b1;
    #1;
    check("mid-edge reset pixel_valid", int'(pixel_valid), 0);
    check("mid-edge reset DrawX", int'(DrawX), 0);
    check("mid-edge reset DrawY", int'(DrawY), 0);
    check("mid-edge reset fifo_r", int'(fifo_r), 0);
    check("mid-edge reset state", int'(dbg_state), int'(IDLE));
    @(negedge Clk); Reset = 1'b0;
    got_q.delete(); pop_cnt = 0; done_cnt = 0;
    repeat (10) @(negedge Clk);
    check("post reset pops", pop_cnt, 0);
    check("post reset pixels", got_q.size(), 0);
    check("post reset done", done_cnt, 0);
    check("post reset state", int'(dbg_state), int'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
